// File: rtl/return_recorder_pkg.sv
// Shared types for the return recorder: entry lifecycle and flush FSM encodings.
package rr_pkg;

  localparam int DEPTH_LOG2_DEF = 6;

  typedef enum logic [1:0] {
    E_FREE    = 2'd0,
    E_PENDING = 2'd1,
    E_DONE    = 2'd2
  } entry_state_e;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_FDONE = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/return_recorder_entry_table.sv
// Per-tag state/type/data storage with independent alloc, completion and pop write ports.
module rr_entry_table
  import rr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_en_i,
  input  logic [DEPTH_LOG2-1:0] alloc_idx_i,
  input  logic                  alloc_is_read_i,
  input  logic                  cmpl_en_i,
  input  logic [DEPTH_LOG2-1:0] cmpl_idx_i,
  input  logic [DATA_WIDTH-1:0] cmpl_data_i,
  input  logic                  pop_en_i,
  input  logic [DEPTH_LOG2-1:0] head_idx_i,
  output entry_state_e          head_state_o,
  output logic                  head_is_read_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output entry_state_e          cmpl_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  entry_state_e          state_q   [DEPTH];
  logic                  is_read_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q    [DEPTH];

  // The three causes always target distinct entries (FREE / PENDING / DONE head).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i]   <= E_FREE;
        is_read_q[i] <= 1'b0;
        data_q[i]    <= '0;
      end
    end else begin
      if (alloc_en_i) begin
        state_q[alloc_idx_i]   <= E_PENDING;
        is_read_q[alloc_idx_i] <= alloc_is_read_i;
        data_q[alloc_idx_i]    <= '0;
      end
      if (cmpl_en_i) begin
        state_q[cmpl_idx_i] <= E_DONE;
        data_q[cmpl_idx_i]  <= is_read_q[cmpl_idx_i] ? cmpl_data_i : '0;
      end
      if (pop_en_i) begin
        state_q[head_idx_i] <= E_FREE;
      end
    end
  end

  assign head_state_o   = state_q[head_idx_i];
  assign head_is_read_o = is_read_q[head_idx_i];
  assign head_data_o    = data_q[head_idx_i];
  assign cmpl_state_o   = state_q[cmpl_idx_i];

endmodule

// File: rtl/return_recorder.sv
// In-order tag allocator / out-of-order completion recorder with an in-order valid/ready head port.
// Handshake: head pops when ret_valid & ret_ready on a posedge; ret_ready alone has no effect.
module return_recorder
  import rr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  input  logic                  alloc_is_read,
  output logic                  alloc_gnt,
  output logic [DEPTH_LOG2-1:0] alloc_tag,
  input  logic                  cmpl_valid,
  input  logic [DEPTH_LOG2-1:0] cmpl_tag,
  input  logic [DATA_WIDTH-1:0] cmpl_data,
  output logic                  ret_valid,
  output logic                  ret_is_read,
  output logic [DATA_WIDTH-1:0] ret_data,
  input  logic                  ret_ready,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [DEPTH_LOG2:0]   outstanding,
  output logic                  full,
  output logic                  empty,
  output logic                  err_cmpl,
  output logic [1:0]            dbg_state
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] retire_ptr_q, retire_ptr_d;
  logic [PW-1:0] outstanding_q, outstanding_d;
  fsm_state_e    state_q;
  logic          flush_done_q;
  logic          err_cmpl_q;

  entry_state_e          head_state;
  entry_state_e          cmpl_state;
  logic                  head_is_read;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  pop;
  logic                  cmpl_ok;

  assign full      = (outstanding_q == CAP);
  assign empty     = (outstanding_q == '0);
  assign alloc_gnt = alloc_req & ~full & (state_q == S_RUN);
  assign alloc_tag = alloc_ptr_q[DEPTH_LOG2-1:0];

  assign ret_valid   = (head_state == E_DONE);
  assign ret_is_read = head_is_read;
  assign ret_data    = head_data;
  assign pop         = ret_valid & ret_ready;
  assign cmpl_ok     = cmpl_valid & (cmpl_state == E_PENDING);

  rr_entry_table #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_table (
    .clk            (clk),
    .rst            (rst),
    .alloc_en_i     (alloc_gnt),
    .alloc_idx_i    (alloc_tag),
    .alloc_is_read_i(alloc_is_read),
    .cmpl_en_i      (cmpl_ok),
    .cmpl_idx_i     (cmpl_tag),
    .cmpl_data_i    (cmpl_data),
    .pop_en_i       (pop),
    .head_idx_i     (retire_ptr_q[DEPTH_LOG2-1:0]),
    .head_state_o   (head_state),
    .head_is_read_o (head_is_read),
    .head_data_o    (head_data),
    .cmpl_state_o   (cmpl_state)
  );

  always_comb begin
    alloc_ptr_d   = alloc_ptr_q + PW'(alloc_gnt);
    retire_ptr_d  = retire_ptr_q + PW'(pop);
    outstanding_d = outstanding_q;
    case ({alloc_gnt, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr_q   <= '0;
      retire_ptr_q  <= '0;
      outstanding_q <= '0;
      err_cmpl_q    <= 1'b0;
    end else begin
      alloc_ptr_q   <= alloc_ptr_d;
      retire_ptr_q  <= retire_ptr_d;
      outstanding_q <= outstanding_d;
      err_cmpl_q    <= cmpl_valid & ~cmpl_ok;
    end
  end

  // flush_done is raised only on the DRAIN->FDONE transition, so it pulses once per drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        S_RUN:   if (flush) state_q <= S_DRAIN;
        S_DRAIN: if (empty) begin
          state_q      <= S_FDONE;
          flush_done_q <= 1'b1;
        end
        S_FDONE: if (!flush) state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign flush_done  = flush_done_q;
  assign err_cmpl    = err_cmpl_q;
  assign outstanding = outstanding_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_return_recorder.sv
// Directed + random bench for return_recorder against an issue-order queue model.
module tb_return_recorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_req, alloc_is_read, alloc_gnt;
  logic [5:0]  alloc_tag;
  logic        cmpl_valid;
  logic [5:0]  cmpl_tag;
  logic [31:0] cmpl_data;
  logic        ret_valid, ret_is_read, ret_ready;
  logic [31:0] ret_data;
  logic        flush, flush_done, full, empty, err_cmpl;
  logic [6:0]  outstanding;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  return_recorder #(.DATA_WIDTH(32), .DEPTH_LOG2(6)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_is_read(alloc_is_read),
    .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .ret_valid(ret_valid), .ret_is_read(ret_is_read), .ret_data(ret_data),
    .ret_ready(ret_ready), .flush(flush), .flush_done(flush_done),
    .outstanding(outstanding), .full(full), .empty(empty),
    .err_cmpl(err_cmpl), .dbg_state(dbg_state)
  );

  // Reference model: entries in issue order; head of queue is the oldest tag.
  typedef struct {
    logic        is_read;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   head_tag, next_tag;
  int   mmode;  // 0 running, 1 draining, 2 drained and holding

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    head_tag = 0;
    next_tag = 0;
    mmode    = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_req = 0; alloc_is_read = 0; cmpl_valid = 0; cmpl_tag = 0;
    cmpl_data = 0; ret_ready = 0; flush = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_cmpl, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
  endtask

  // One clock cycle: drive, check comb outputs, advance model, check registered outputs.
  task automatic step(input logic a_req, input logic a_rd, input logic c_v,
                      input logic [5:0] c_tag, input logic [31:0] c_data,
                      input logic r_rdy, input logic f);
    logic exp_gnt, exp_rv, exp_err, exp_fd, legal;
    int   pos;
    alloc_req = a_req; alloc_is_read = a_rd; cmpl_valid = c_v; cmpl_tag = c_tag;
    cmpl_data = c_data; ret_ready = r_rdy; flush = f;
    #1;
    exp_gnt = a_req && (mq.size() < 64) && (mmode == 0);
    exp_rv  = (mq.size() > 0) && mq[0].done;
    chk("alloc_gnt", alloc_gnt, exp_gnt);
    chk("alloc_tag", alloc_tag, next_tag);
    chk("ret_valid", ret_valid, exp_rv);
    if (exp_rv) begin
      chk("ret_is_read", ret_is_read, mq[0].is_read);
      chk("ret_data", ret_data, mq[0].data);
    end
    exp_fd = 0;
    case (mmode)
      0: if (f) mmode = 1;
      1: if (mq.size() == 0) begin mmode = 2; exp_fd = 1; end
      default: if (!f) mmode = 0;
    endcase
    legal = 0;
    if (c_v) begin
      pos = (int'(c_tag) - head_tag + 64) % 64;
      if (pos < mq.size() && !mq[pos].done) begin
        mq[pos].done = 1;
        mq[pos].data = mq[pos].is_read ? c_data : 32'd0;
        legal = 1;
      end
    end
    exp_err = c_v && !legal;
    if (exp_rv && r_rdy) begin
      void'(mq.pop_front());
      head_tag = (head_tag + 1) % 64;
    end
    if (exp_gnt) begin
      mq.push_back('{is_read: a_rd, done: 1'b0, data: 32'd0});
      next_tag = (next_tag + 1) % 64;
    end
    @(posedge clk); #1;
    chk("outstanding", outstanding, mq.size());
    chk("full", full, mq.size() == 64);
    chk("empty", empty, mq.size() == 0);
    chk("err_cmpl", err_cmpl, exp_err);
    chk("flush_done", flush_done, exp_fd);
  endtask

  task automatic idle(input logic f);
    step(0, 0, 0, 0, 0, 0, f);
  endtask

  initial begin
    int n, pick;
    int cand[$];
    model_reset();
    do_reset();

    // 1: read + write, out-of-order completion, in-order return
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t1_outstanding2", outstanding, 2);
    step(0, 0, 1, 6'd1, 32'h1234_5678, 0, 0);
    chk("t1_head_not_ready", ret_valid, 0);
    step(0, 0, 1, 6'd0, 32'hDEAD_BEEF, 0, 0);
    chk("t1_head_ready", ret_valid, 1);
    chk("t1_read_data", ret_data, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t1_write_data_zero", ret_data, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t1_outstanding0", outstanding, 0);

    // 2: fill to 64, blocked alloc with same-cycle pop, then wrap
    do_reset();
    for (int i = 0; i < 64; i++) step(1, i[0], 0, 0, 0, 0, 0);
    chk("t2_full", full, 1);
    step(0, 0, 1, 6'd0, 32'hA5A5_0000, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    chk("t2_after_pop_tag", alloc_tag, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t2_full_again", full, 1);

    // 3: complete 5..1 in reverse, then 0, then drain with ret_ready held
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 0, 0);
    for (int t = 5; t >= 1; t--) step(0, 0, 1, 6'(t), 32'(32'h100 + t), 1, 0);
    step(0, 0, 1, 6'd0, 32'h100, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("t3_empty", empty, 1);

    // 4: illegal completions to a FREE tag and to an already DONE tag
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 6'd9, 32'hBAD0_0009, 0, 0);
    chk("t4_err_free", err_cmpl, 1);
    step(0, 0, 1, 6'd0, 32'h0000_0AAA, 0, 0);
    step(0, 0, 1, 6'd0, 32'hBAD0_0000, 0, 0);
    chk("t4_err_dup", err_cmpl, 1);
    chk("t4_data_kept", ret_data, 32'h0000_0AAA);
    step(1, 0, 1, 6'd2, 32'h0, 0, 0);  // completion to the tag being allocated
    chk("t4_err_same_cycle", err_cmpl, 1);
    idle(0);

    // 5: flush with 3 pending
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    for (int t = 0; t < 3; t++) step(1, 0, 1, 6'(t), 32'(t + 7), 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("t5_running_again", outstanding, 1);

    // 6: reset mid-traffic
    step(0, 0, 1, 6'd3, 32'h77, 0, 0);
    do_reset();
    step(1, 0, 0, 0, 0, 1, 0);

    // Random traffic, mostly legal completions, occasional stray tags and flushes
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic cv, fl;
      logic [5:0] ct;
      cand.delete();
      foreach (mq[k]) if (!mq[k].done) cand.push_back(k);
      cv = 0; ct = 6'($urandom_range(0, 63));
      if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
        pick = cand[$urandom_range(0, cand.size() - 1)];
        ct = 6'((head_tag + pick) % 64);
        cv = 1;
      end else if ($urandom_range(0, 15) == 0) begin
        cv = 1;
      end
      n  = int'($urandom_range(0, 199));
      fl = (cyc % 700) > 600;
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1), cv, ct,
           $urandom, $urandom_range(0, 2) != 0, fl);
      if (n == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
